// File: rtl/pkt_arb_pkg.sv
// Shared types and constants for the packet-source arbiter.
package pkt_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } arb_state_e;

  localparam logic [1:0] LINK_UP = 2'b11;

endpackage

// File: rtl/pkt_src_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping.
module rr_pick #(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]         req,
  input  logic [$clog2(NUM_SRC)-1:0] ptr,
  output logic                       valid,
  output logic [$clog2(NUM_SRC)-1:0] idx
);
  localparam int IW = $clog2(NUM_SRC);

  logic [IW-1:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = ptr;
    cand  = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      cand = IW'((int'(ptr) + i) % NUM_SRC);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/pkt_src_arbiter.sv
// Round-robin arbiter sharing the link controller's packet-transmit port
// between NUM_SRC sources, with link-down abort and transfer timeout.
module pkt_src_arbiter
  import pkt_arb_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    link_state,
  input  logic [NUM_SRC-1:0]            src_req,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]            src_ack,
  output logic                          pkt_req,
  output logic [DATA_WIDTH-1:0]         pkt_data,
  input  logic                          pkt_ack,
  input  logic                          pkt_eop,
  output logic [$clog2(NUM_SRC)-1:0]    grant_id,
  output logic                          busy,
  output logic                          done,
  output logic                          err_timeout,
  output logic                          err_abort
);
  localparam int IW = $clog2(NUM_SRC);
  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_e              state_q;
  logic [IW-1:0]           ptr_q;
  logic                    ack_q;
  logic [CW-1:0]           cnt_q;
  logic [CW-1:0]           cnt_d;
  logic                    link_up;
  logic                    acc;
  logic                    pick_valid;
  logic [IW-1:0]           pick_idx;
  logic [DATA_WIDTH-1:0]   pick_data;

  assign link_up = (link_state == LINK_UP);
  // Only a rising edge of the level-style ack counts as a new accept.
  assign acc     = pkt_ack & ~ack_q;
  assign cnt_d   = cnt_q + CW'(1);

  rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .req   (src_req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pick_idx == IW'(i)) pick_data = src_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= IW'(NUM_SRC - 1);
      ack_q       <= 1'b0;
      cnt_q       <= '0;
      src_ack     <= '0;
      pkt_req     <= 1'b0;
      pkt_data    <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      err_abort   <= 1'b0;
    end else begin
      ack_q       <= pkt_ack;
      src_ack     <= '0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      err_abort   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (link_up && pick_valid) begin
            grant_id <= pick_idx;
            pkt_data <= pick_data;
            pkt_req  <= 1'b1;
            busy     <= 1'b1;
            state_q  <= REQ;
          end
        end
        REQ: begin
          if (acc) begin
            pkt_req <= 1'b0;
            src_ack <= NUM_SRC'(1) << grant_id;
            cnt_q   <= '0;
            state_q <= XFER;
          end else if (!link_up) begin
            pkt_req <= 1'b0;
            busy    <= 1'b0;
            state_q <= IDLE;
          end
        end
        XFER: begin
          cnt_q <= cnt_d;
          // Exit priority: eop, then link-down, then timeout.
          if (pkt_eop || !link_up || cnt_d == CW'(TIMEOUT)) begin
            done        <= pkt_eop;
            err_abort   <= !pkt_eop && !link_up;
            err_timeout <= pkt_eop == 1'b0 && link_up;
            ptr_q       <= grant_id;
            busy        <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_src_arbiter.sv
// Directed testbench for pkt_src_arbiter (NUM_SRC=4, DATA_WIDTH=32, TIMEOUT=16).
module tb_pkt_src_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   link_state;
  logic [3:0]   src_req;
  logic [127:0] src_data;
  logic [3:0]   src_ack;
  logic         pkt_req;
  logic [31:0]  pkt_data;
  logic         pkt_ack;
  logic         pkt_eop;
  logic [1:0]   grant_id;
  logic         busy;
  logic         done;
  logic         err_timeout;
  logic         err_abort;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] D0 = 32'hC0C0_0000;
  localparam logic [31:0] D1 = 32'hB1B1_0001;
  localparam logic [31:0] D2 = 32'hA5A5_0001;
  localparam logic [31:0] D3 = 32'hD3D3_0003;

  pkt_src_arbiter #(.NUM_SRC(4), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .link_state  (link_state),
    .src_req     (src_req),
    .src_data    (src_data),
    .src_ack     (src_ack),
    .pkt_req     (pkt_req),
    .pkt_data    (pkt_data),
    .pkt_ack     (pkt_ack),
    .pkt_eop     (pkt_eop),
    .grant_id    (grant_id),
    .busy        (busy),
    .done        (done),
    .err_timeout (err_timeout),
    .err_abort   (err_abort)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one full ack/eop handshake and reports what the DUT showed.
  task automatic run_pkt(output logic [1:0] gid, output logic [31:0] data,
                         output logic [3:0] ack_seen, output logic done_seen);
    for (int i = 0; i < 50 && !pkt_req; i++) step();
    if (!pkt_req) begin
      gid = 2'bxx; data = 'x; ack_seen = 4'bxxxx; done_seen = 1'bx;
    end else begin
      gid     = grant_id;
      data    = pkt_data;
      pkt_ack = 1'b1;
      step();
      ack_seen = src_ack;
      pkt_ack  = 1'b0;
      pkt_eop  = 1'b1;
      step();
      done_seen = done;
      pkt_eop   = 1'b0;
    end
  endtask

  task automatic test_reset();
    step();
    step();
    total++;
    if ({pkt_req, busy, done, err_timeout, err_abort} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 00000", {pkt_req, busy, done, err_timeout, err_abort});
    end
    total++;
    if ({src_ack, grant_id, pkt_data} !== 38'd0) begin
      bad++; $display("FAIL reset_data: got ack=%b gid=%0d data=%h want 0", src_ack, grant_id, pkt_data);
    end
    rst = 1'b0;
    step();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL reset_idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_single();
    link_state = 2'b11;
    src_req    = 4'b0100;
    step();
    total++;
    if (pkt_req !== 1'b1 || grant_id !== 2'd2 || pkt_data !== D2 || busy !== 1'b1) begin
      bad++; $display("FAIL single_grant: got req=%b gid=%0d data=%h busy=%b want 1 2 %h 1", pkt_req, grant_id, pkt_data, busy, D2);
    end
    step();
    step();
    total++;
    if (pkt_req !== 1'b1 || src_ack !== 4'b0000) begin
      bad++; $display("FAIL single_wait: got req=%b ack=%b want 1 0000", pkt_req, src_ack);
    end
    pkt_ack = 1'b1;
    step();
    total++;
    if (src_ack !== 4'b0100 || pkt_req !== 1'b0) begin
      bad++; $display("FAIL single_ack: got ack=%b req=%b want 0100 0", src_ack, pkt_req);
    end
    src_req = 4'b0000;
    pkt_ack = 1'b0;
    step();
    total++;
    if (src_ack !== 4'b0000 || busy !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL single_xfer: got ack=%b busy=%b done=%b want 0000 1 0", src_ack, busy, done);
    end
    pkt_eop = 1'b1;
    step();
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL single_done: got done=%b busy=%b want 1 0", done, busy);
    end
    pkt_eop = 1'b0;
    step();
    total++;
    if (done !== 1'b0 || pkt_data !== D2) begin
      bad++; $display("FAIL single_after: got done=%b data=%h want 0 %h", done, pkt_data, D2);
    end
  endtask

  task automatic test_fairness();
    logic [1:0]  exp_id [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [31:0] exp_d  [4] = '{D0, D1, D2, D3};
    logic [1:0]  gid;
    logic [31:0] data;
    logic [3:0]  ack_seen;
    logic        done_seen;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    src_req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      run_pkt(gid, data, ack_seen, done_seen);
      total++;
      if (gid !== exp_id[k] || data !== exp_d[exp_id[k]]) begin
        bad++; $display("FAIL fair_grant%0d: got gid=%0d data=%h want %0d %h", k, gid, data, exp_id[k], exp_d[exp_id[k]]);
      end
      total++;
      if (ack_seen !== (4'b0001 << exp_id[k]) || done_seen !== 1'b1) begin
        bad++; $display("FAIL fair_ack%0d: got ack=%b done=%b want %b 1", k, ack_seen, done_seen, 4'b0001 << exp_id[k]);
      end
    end
    src_req = 4'b0000;
    step();
  endtask

  task automatic test_link_gating();
    logic [1:0]  gid;
    logic [31:0] data;
    logic [3:0]  ack_seen;
    logic        done_seen;
    int          seen_req = 0;
    link_state = 2'b01;
    src_req    = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      step();
      if (pkt_req !== 1'b0) seen_req++;
    end
    total++;
    if (seen_req != 0) begin
      bad++; $display("FAIL gate_hold: got %0d cycles with pkt_req want 0", seen_req);
    end
    link_state = 2'b11;
    step();
    total++;
    if (pkt_req !== 1'b1 || grant_id !== 2'd0) begin
      bad++; $display("FAIL gate_release: got req=%b gid=%0d want 1 0", pkt_req, grant_id);
    end
    run_pkt(gid, data, ack_seen, done_seen);
    src_req = 4'b0000;
    total++;
    if (ack_seen !== 4'b0001 || done_seen !== 1'b1) begin
      bad++; $display("FAIL gate_pkt: got ack=%b done=%b want 0001 1", ack_seen, done_seen);
    end
  endtask

  task automatic test_stuck_ack();
    int early = 0;
    src_req = 4'b0010;
    step();
    pkt_ack = 1'b1;
    step();
    total++;
    if (src_ack !== 4'b0010) begin
      bad++; $display("FAIL stuck_first: got ack=%b want 0010", src_ack);
    end
    src_req = 4'b0000;
    pkt_eop = 1'b1;
    step();
    pkt_eop = 1'b0;
    src_req = 4'b0100;
    step();
    total++;
    if (pkt_req !== 1'b1 || grant_id !== 2'd2) begin
      bad++; $display("FAIL stuck_req: got req=%b gid=%0d want 1 2", pkt_req, grant_id);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (src_ack !== 4'b0000 || pkt_req !== 1'b1) early++;
    end
    pkt_ack = 1'b0;
    step();
    if (src_ack !== 4'b0000) early++;
    total++;
    if (early != 0) begin
      bad++; $display("FAIL stuck_hold: got %0d early accepts want 0", early);
    end
    pkt_ack = 1'b1;
    step();
    total++;
    if (src_ack !== 4'b0100) begin
      bad++; $display("FAIL stuck_second: got ack=%b want 0100", src_ack);
    end
    src_req = 4'b0000;
    pkt_ack = 1'b0;
    pkt_eop = 1'b1;
    step();
    pkt_eop = 1'b0;
  endtask

  task automatic test_timeout();
    int early = 0;
    src_req = 4'b1000;
    step();
    pkt_ack = 1'b1;
    step();
    src_req = 4'b0000;
    pkt_ack = 1'b0;
    for (int i = 1; i < 16; i++) begin
      step();
      if (err_timeout !== 1'b0 || busy !== 1'b1) early++;
    end
    total++;
    if (early != 0) begin
      bad++; $display("FAIL tmo_early: got %0d bad cycles want 0", early);
    end
    step();
    total++;
    if (err_timeout !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err_abort !== 1'b0) begin
      bad++; $display("FAIL tmo_pulse: got tmo=%b busy=%b done=%b abort=%b want 1 0 0 0", err_timeout, busy, done, err_abort);
    end
    src_req = 4'b1001;
    step();
    total++;
    if (err_timeout !== 1'b0 || grant_id !== 2'd0) begin
      bad++; $display("FAIL tmo_ptr: got tmo=%b gid=%0d want 0 0", err_timeout, grant_id);
    end
    pkt_ack = 1'b1;
    step();
    src_req    = 4'b0000;
    pkt_ack    = 1'b0;
    pkt_eop    = 1'b1;
    link_state = 2'b00;
    step();
    total++;
    if (done !== 1'b1 || err_abort !== 1'b0 || err_timeout !== 1'b0) begin
      bad++; $display("FAIL tmo_eop_prio: got done=%b abort=%b tmo=%b want 1 0 0", done, err_abort, err_timeout);
    end
    pkt_eop    = 1'b0;
    link_state = 2'b11;
  endtask

  task automatic test_abort_reset();
    src_req = 4'b0110;
    step();
    total++;
    if (pkt_req !== 1'b1 || grant_id !== 2'd1) begin
      bad++; $display("FAIL abort_grant: got req=%b gid=%0d want 1 1", pkt_req, grant_id);
    end
    link_state = 2'b01;
    step();
    total++;
    if (pkt_req !== 1'b0 || busy !== 1'b0 || src_ack !== 4'b0000 || err_abort !== 1'b0) begin
      bad++; $display("FAIL abort_req: got req=%b busy=%b ack=%b abort=%b want 0 0 0000 0", pkt_req, busy, src_ack, err_abort);
    end
    link_state = 2'b11;
    step();
    total++;
    if (pkt_req !== 1'b1 || grant_id !== 2'd1) begin
      bad++; $display("FAIL abort_ptr_kept: got req=%b gid=%0d want 1 1", pkt_req, grant_id);
    end
    pkt_ack = 1'b1;
    step();
    src_req    = 4'b0100;
    pkt_ack    = 1'b0;
    link_state = 2'b00;
    step();
    total++;
    if (err_abort !== 1'b1 || done !== 1'b0 || err_timeout !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL abort_xfer: got abort=%b done=%b tmo=%b busy=%b want 1 0 0 0", err_abort, done, err_timeout, busy);
    end
    link_state = 2'b11;
    step();
    total++;
    if (err_abort !== 1'b0 || pkt_req !== 1'b1 || grant_id !== 2'd2 || pkt_data !== D2) begin
      bad++; $display("FAIL abort_next: got abort=%b req=%b gid=%0d data=%h want 0 1 2 %h", err_abort, pkt_req, grant_id, pkt_data, D2);
    end
    pkt_ack = 1'b1;
    step();
    src_req = 4'b0000;
    pkt_ack = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({src_ack, pkt_req, pkt_data, grant_id, busy, done, err_timeout, err_abort} !== 43'd0) begin
      bad++; $display("FAIL reset_async: got ack=%b req=%b data=%h gid=%0d busy=%b want all 0", src_ack, pkt_req, pkt_data, grant_id, busy);
    end
    #1;
    rst = 1'b0;
    step();
    step();
    total++;
    if ({done, err_timeout, err_abort, busy} !== 4'b0) begin
      bad++; $display("FAIL reset_quiet: got %b want 0000", {done, err_timeout, err_abort, busy});
    end
  endtask

  initial begin
    rst        = 1'b1;
    link_state = 2'b00;
    src_req    = 4'b0000;
    src_data   = {D3, D2, D1, D0};
    pkt_ack    = 1'b0;
    pkt_eop    = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_link_gating();
    test_stuck_ack();
    test_timeout();
    test_abort_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
